// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: per-cycle HOLD (memory stall), BUBBLE (hazard/flush)
// or LOAD, plus a saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             NoOp_i,
  input  logic             Flush_i,
  input  logic             MemStall_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             ALUSrc_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [31:0]      RS1data_i,
  input  logic [31:0]      RS2data_i,
  input  logic [31:0]      Imm_i,
  input  logic [31:0]      PC_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       Rs1_i,
  input  logic [4:0]       Rs2_i,
  input  logic [4:0]       Rd_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic [31:0]      RS1data_o,
  output logic [31:0]      RS2data_o,
  output logic [31:0]      Imm_o,
  output logic [31:0]      PC_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       Rs1_o,
  output logic [4:0]       Rs2_o,
  output logic [4:0]       Rd_o,
  output logic             Valid_o,
  output logic [CNT_W-1:0] BubbleCnt_o
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_HOLD   = 2'd2
  } action_e;

  action_e action;

  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             memread_q,  memread_d;
  logic             memwrite_q, memwrite_d;
  logic             alusrc_q,   alusrc_d;
  logic [1:0]       aluop_q,    aluop_d;
  logic [31:0]      rs1data_q,  rs1data_d;
  logic [31:0]      rs2data_q,  rs2data_d;
  logic [31:0]      imm_q,      imm_d;
  logic [31:0]      pc_q,       pc_d;
  logic [9:0]       funct_q,    funct_d;
  logic [4:0]       rs1_q,      rs1_d;
  logic [4:0]       rs2_q,      rs2_d;
  logic [4:0]       rd_q,       rd_d;
  logic             valid_q,    valid_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // Stall dominates; a simultaneous NoOp and Flush is still one bubble.
  always_comb begin
    if (MemStall_i)
      action = ACT_HOLD;
    else if (NoOp_i || Flush_i)
      action = ACT_BUBBLE;
    else
      action = ACT_LOAD;
  end

  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    aluop_d    = aluop_q;
    rs1data_d  = rs1data_q;
    rs2data_d  = rs2data_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    funct_d    = funct_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;

    // Data fields travel on both LOAD and BUBBLE; only controls are squashed.
    if (action != ACT_HOLD) begin
      rs1data_d = RS1data_i;
      rs2data_d = RS2data_i;
      imm_d     = Imm_i;
      pc_d      = PC_i;
      funct_d   = funct_i;
      rs1_d     = Rs1_i;
      rs2_d     = Rs2_i;
    end

    case (action)
      ACT_LOAD: begin
        regwrite_d = RegWrite_i;
        memtoreg_d = MemtoReg_i;
        memread_d  = MemRead_i;
        memwrite_d = MemWrite_i;
        alusrc_d   = ALUSrc_i;
        aluop_d    = ALUOp_i;
        rd_d       = Rd_i;
        valid_d    = 1'b1;
      end
      ACT_BUBBLE: begin
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        alusrc_d   = 1'b0;
        aluop_d    = '0;
        rd_d       = '0;
        valid_d    = 1'b0;
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      aluop_q    <= '0;
      rs1data_q  <= '0;
      rs2data_q  <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      funct_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      aluop_q    <= aluop_d;
      rs1data_q  <= rs1data_d;
      rs2data_q  <= rs2data_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      funct_q    <= funct_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign RegWrite_o  = regwrite_q;
  assign MemtoReg_o  = memtoreg_q;
  assign MemRead_o   = memread_q;
  assign MemWrite_o  = memwrite_q;
  assign ALUSrc_o    = alusrc_q;
  assign ALUOp_o     = aluop_q;
  assign RS1data_o   = rs1data_q;
  assign RS2data_o   = rs2data_q;
  assign Imm_o       = imm_q;
  assign PC_o        = pc_q;
  assign funct_o     = funct_q;
  assign Rs1_o       = rs1_q;
  assign Rs2_o       = rs2_q;
  assign Rd_o        = rd_q;
  assign Valid_o     = valid_q;
  assign BubbleCnt_o = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed-vector bench for id_ex_reg (CNT_W=4 so counter saturation is reachable).
module tb_id_ex_reg;

  localparam int unsigned CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             NoOp_i, Flush_i, MemStall_i;
  logic             RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
  logic [1:0]       ALUOp_i;
  logic [31:0]      RS1data_i, RS2data_i, Imm_i, PC_i;
  logic [9:0]       funct_i;
  logic [4:0]       Rs1_i, Rs2_i, Rd_i;
  logic             RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o;
  logic [1:0]       ALUOp_o;
  logic [31:0]      RS1data_o, RS2data_o, Imm_o, PC_o;
  logic [9:0]       funct_o;
  logic [4:0]       Rs1_o, Rs2_o, Rd_o;
  logic             Valid_o;
  logic [CNT_W-1:0] BubbleCnt_o;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned exp_cnt;

  id_ex_reg #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .NoOp_i(NoOp_i), .Flush_i(Flush_i), .MemStall_i(MemStall_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .PC_i(PC_i),
    .funct_i(funct_i), .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rd_i(Rd_i),
    .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .PC_o(PC_o),
    .funct_o(funct_o), .Rs1_o(Rs1_o), .Rs2_o(Rs2_o), .Rd_o(Rd_o),
    .Valid_o(Valid_o), .BubbleCnt_o(BubbleCnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_in();
    NoOp_i = 0; Flush_i = 0; MemStall_i = 0;
    RegWrite_i = 0; MemtoReg_i = 0; MemRead_i = 0; MemWrite_i = 0; ALUSrc_i = 0;
    ALUOp_i = '0; RS1data_i = '0; RS2data_i = '0; Imm_i = '0; PC_i = '0;
    funct_i = '0; Rs1_i = '0; Rs2_i = '0; Rd_i = '0;
  endtask

  task automatic junk_in();
    RegWrite_i = 1; MemtoReg_i = 1; MemRead_i = 1; MemWrite_i = 1; ALUSrc_i = 1;
    ALUOp_i = 2'b11; RS1data_i = $urandom; RS2data_i = $urandom; Imm_i = $urandom;
    PC_i = $urandom; funct_i = 10'h3FF; Rs1_i = 5'd31; Rs2_i = 5'd30; Rd_i = 5'd29;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {25'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                           ALUSrc_o, ALUOp_o}, 32'd0);
    check({tag, "_rs1d"}, RS1data_o, 32'd0);
    check({tag, "_rs2d"}, RS2data_o, 32'd0);
    check({tag, "_imm"},  Imm_o, 32'd0);
    check({tag, "_pc"},   PC_o, 32'd0);
    check({tag, "_idx"},  {7'd0, funct_o, Rs1_o, Rs2_o, Rd_o}, 32'd0);
    check({tag, "_vld"},  {31'd0, Valid_o}, 32'd0);
    check({tag, "_cnt"},  {28'd0, BubbleCnt_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1;
    clear_in();
    junk_in();
    #2 rst_i = 0;
    #1 check_zero("rst_async");
    // Inputs toggle while reset is held: nothing may be captured.
    NoOp_i = 1;
    tick();
    NoOp_i = 0;
    junk_in();
    tick();
    check_zero("rst_hold");

    // Simple load
    rst_i = 1;
    clear_in();
    RegWrite_i = 1; MemRead_i = 1; Rd_i = 5'd5; RS1data_i = 32'h1234_5678;
    tick();
    check("ld_regw", {31'd0, RegWrite_o}, 32'd1);
    check("ld_memrd", {31'd0, MemRead_o}, 32'd1);
    check("ld_rd", {27'd0, Rd_o}, 32'd5);
    check("ld_rs1d", RS1data_o, 32'h1234_5678);
    check("ld_vld", {31'd0, Valid_o}, 32'd1);
    check("ld_cnt", {28'd0, BubbleCnt_o}, 32'd0);

    // NoOp bubble
    clear_in();
    NoOp_i = 1; RegWrite_i = 1; MemWrite_i = 1; Rd_i = 5'd7; Imm_i = 32'h10;
    tick();
    check("bub_ctrl", {25'd0, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
                       ALUSrc_o, ALUOp_o}, 32'd0);
    check("bub_rd", {27'd0, Rd_o}, 32'd0);
    check("bub_vld", {31'd0, Valid_o}, 32'd0);
    check("bub_imm", Imm_o, 32'h10);
    check("bub_cnt", {28'd0, BubbleCnt_o}, 32'd1);

    // Stall outranks NoOp/Flush for 3 cycles
    for (int i = 0; i < 3; i++) begin
      clear_in();
      MemStall_i = 1; NoOp_i = 1; Flush_i = (i == 1);
      RegWrite_i = 1; MemRead_i = 1; Rd_i = 5'(20 + i); Imm_i = 32'h100 + i;
      PC_i = 32'hA0 + i;
      tick();
      check("stl_imm", Imm_o, 32'h10);
      check("stl_pc", PC_o, 32'd0);
      check("stl_ctrl", {30'd0, RegWrite_o, MemRead_o}, 32'd0);
      check("stl_rd", {27'd0, Rd_o}, 32'd0);
      check("stl_cnt", {28'd0, BubbleCnt_o}, 32'd1);
    end
    clear_in();
    NoOp_i = 1; RegWrite_i = 1; Imm_i = 32'h55; PC_i = 32'h44;
    tick();
    check("unstl_imm", Imm_o, 32'h55);
    check("unstl_pc", PC_o, 32'h44);
    check("unstl_regw", {31'd0, RegWrite_o}, 32'd0);
    check("unstl_cnt", {28'd0, BubbleCnt_o}, 32'd2);

    // NoOp and Flush together is one bubble
    clear_in();
    NoOp_i = 1; Flush_i = 1; Rs2_i = 5'd12; funct_i = 10'h2A5;
    tick();
    check("both_cnt", {28'd0, BubbleCnt_o}, 32'd3);
    check("both_rs2", {27'd0, Rs2_o}, 32'd12);
    check("both_funct", {22'd0, funct_o}, 32'h2A5);

    // Load-use: load with Rd=3, then hazard unit bubbles the dependent instruction
    clear_in();
    MemRead_i = 1; MemtoReg_i = 1; RegWrite_i = 1; Rd_i = 5'd3; ALUOp_i = 2'b00;
    ALUSrc_i = 1;
    tick();
    check("lu_memrd", {31'd0, MemRead_o}, 32'd1);
    check("lu_rd", {27'd0, Rd_o}, 32'd3);
    check("lu_alusrc", {31'd0, ALUSrc_o}, 32'd1);
    clear_in();
    NoOp_i = 1; Rs1_i = 5'd3; RegWrite_i = 1; ALUOp_i = 2'b10; Rd_i = 5'd8;
    tick();
    check("lu_bub_memrd", {31'd0, MemRead_o}, 32'd0);
    check("lu_bub_rd", {27'd0, Rd_o}, 32'd0);
    check("lu_bub_vld", {31'd0, Valid_o}, 32'd0);
    check("lu_bub_rs1", {27'd0, Rs1_o}, 32'd3);
    check("lu_bub_cnt", {28'd0, BubbleCnt_o}, 32'd4);
    clear_in();
    Rs1_i = 5'd3; RegWrite_i = 1; ALUOp_i = 2'b10; Rd_i = 5'd8;
    tick();
    check("lu_re_vld", {31'd0, Valid_o}, 32'd1);
    check("lu_re_aluop", {30'd0, ALUOp_o}, 32'd2);
    check("lu_re_rd", {27'd0, Rd_o}, 32'd8);

    // Saturation over 20 consecutive flushes
    exp_cnt = 4;
    for (int i = 0; i < 20; i++) begin
      clear_in();
      Flush_i = 1; NoOp_i = (i % 3 == 0); PC_i = 32'h1000 + 4 * i;
      tick();
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      check("sat_cnt", {28'd0, BubbleCnt_o}, exp_cnt);
    end
    check("sat_final", {28'd0, BubbleCnt_o}, 32'd15);
    check("sat_pc", PC_o, 32'h1000 + 4 * 19);

    // Async reset between edges
    clear_in();
    MemRead_i = 1; Rd_i = 5'd9;
    tick();
    check("ar_pre_rd", {27'd0, Rd_o}, 32'd9);
    #2 rst_i = 0;
    #1 check_zero("ar");
    #2 rst_i = 1;

    // Reset while holding discards the held instruction
    clear_in();
    RegWrite_i = 1; Rd_i = 5'd4; Imm_i = 32'hBEEF;
    tick();
    check("mh_rd", {27'd0, Rd_o}, 32'd4);
    MemStall_i = 1;
    tick();
    check("mh_hold_imm", Imm_o, 32'hBEEF);
    #2 rst_i = 0;
    #1 check_zero("mh_rst");
    #2 rst_i = 1;
    tick();
    check_zero("mh_post");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
